// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: snoops a multiplexed 7-seg bus, glitch-filters it, decodes codes and reports per-digit changes.
module seg7_scan_decoder #(
  parameter int NDIG       = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg_in,
  input  logic [NDIG-1:0]   dig_sel,
  input  logic              clr_sticky,
  output logic [5*NDIG-1:0] code_out,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [2:0]        evt_digit,
  output logic [4:0]        evt_code,
  output logic              bad_pat,
  output logic              ovf
);
  logic [6:0]      seg_i, seg_r, cand_pat, acc_pat;
  logic [NDIG-1:0] dig_i, dig_r;
  logic [2:0]      sidx, cand_idx, acc_idx;
  logic [3:0]      cnt, cnt_nxt;
  logic            svalid, same, acc, acc_r, ev, take;
  logic [4:0]      dcode, cur;
`ifdef SEG7_ACTIVE_LOW_EN
  assign seg_i = ~seg_in;
  assign dig_i = ~dig_sel;
`else
  assign seg_i = seg_in;
  assign dig_i = dig_sel;
`endif
  function automatic logic [4:0] dec(input logic [6:0] p);
    case (p)
      7'h7E: dec = 5'h00;
      7'h30: dec = 5'h01;
      7'h6D: dec = 5'h02;
      7'h79: dec = 5'h03;
      7'h33: dec = 5'h04;
      7'h5B: dec = 5'h05;
      7'h5F: dec = 5'h06;
      7'h72: dec = 5'h07;
      7'h7F: dec = 5'h08;
      7'h7B: dec = 5'h09;
      7'h77: dec = 5'h0A;
      7'h1F: dec = 5'h0B;
      7'h4E: dec = 5'h0C;
      7'h3D: dec = 5'h0D;
      7'h4F: dec = 5'h0E;
      7'h47: dec = 5'h0F;
      7'h00: dec = 5'h10;
      7'h01: dec = 5'h11;
      7'h0E: dec = 5'h12;
      default: dec = 5'h1F;
    endcase
  endfunction
  always_comb begin
    sidx = '0;
    for (int i = 0; i < NDIG; i++)
      if (dig_r[i]) sidx = 3'(i);
  end
  assign svalid  = (dig_r != '0) && ((dig_r & (dig_r - NDIG'(1))) == '0);
  assign same    = (cnt != '0) && (sidx == cand_idx) && (seg_r == cand_pat);
  assign cnt_nxt = same ? ((cnt == 4'(STABLE_CNT)) ? cnt : cnt + 4'd1) : 4'd1;
  // fire only on the transition into STABLE_CNT so a held pattern is accepted once
  assign acc     = svalid && (cnt_nxt == 4'(STABLE_CNT)) && !(same && cnt == 4'(STABLE_CNT));
  assign dcode   = dec(acc_pat);
  assign cur     = code_out[5*int'(acc_idx) +: 5];
  assign ev      = acc_r && (dcode != cur);
  assign take    = evt_valid && evt_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r     <= '0;
      dig_r     <= '0;
      cand_pat  <= '0;
      cand_idx  <= '0;
      cnt       <= '0;
      acc_r     <= 1'b0;
      acc_pat   <= '0;
      acc_idx   <= '0;
      code_out  <= {NDIG{5'h10}};
      evt_valid <= 1'b0;
      evt_digit <= '0;
      evt_code  <= '0;
      bad_pat   <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      seg_r <= seg_i;
      dig_r <= dig_i;
      cnt   <= svalid ? cnt_nxt : 4'd0;
      if (svalid) begin
        cand_pat <= seg_r;
        cand_idx <= sidx;
      end
      acc_r <= acc;
      if (acc) begin
        acc_pat <= seg_r;
        acc_idx <= sidx;
      end
      if (ev) code_out[5*int'(acc_idx) +: 5] <= dcode;
      if (ev && (!evt_valid || evt_ready)) begin
        evt_valid <= 1'b1;
        evt_digit <= acc_idx;
        evt_code  <= dcode;
      end else if (take) evt_valid <= 1'b0;
      bad_pat <= (acc_r && dcode == 5'h1F) || (bad_pat && !clr_sticky);
      ovf     <= (ev && evt_valid && !evt_ready) || (ovf && !clr_sticky);
    end
  end
endmodule
